down_timer: RTL and testbench

- Loadable down-counter with a one-shot / auto-reload timer FSM; the counting-down counterpart of the existing 4-bit incrementor.
- Intended use: generating timed delays, periodic ticks and terminal-count events for level-1 sequential exercises.
- Sits beside the incrementor and is driven by the same clk/rst_ pair.
- Output is a registered count plus status flags; no combinational path from inputs to outputs.

---
 rtl/level1_pkg.sv | 12 +
 rtl/down_timer.sv | 92 +++++++++
 tb/tb_down_timer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/level1_pkg.sv
// Shared types and defaults for the level-1 sequential exercise blocks.
package level1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    localparam int TIMER_W_DEFAULT = 4;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / auto-reload sequencing and a one-cycle
// terminal-count pulse. Every output comes straight from a flop.
module down_timer
    import level1_pkg::*;
#(
    parameter int unsigned W = TIMER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         en,
    input  logic         auto_reload,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done,
    output logic         tc
);

    timer_state_t state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;
    logic         busy_q, done_q;

    // Next-state: load beats start, start beats the enabled decrement.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (count_q == W'(1)) begin
                            tc_d = 1'b1;
                            if (auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q - W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: a behavioural model queues the expected
// post-edge outputs, a monitor pops them after each edge; tasks add targeted checks.
module tb_down_timer;
    import level1_pkg::*;

    logic       clk;
    logic       rst_;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       en;
    logic       auto_reload;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       tc;

    typedef struct packed {
        logic [3:0] count;
        logic       busy;
        logic       done;
        logic       tc;
    } exp_t;

    exp_t         sb_q[$];
    int           vec_cnt = 0;
    int           err_cnt = 0;

    logic [3:0]   m_count;
    logic [3:0]   m_reload;
    timer_state_t m_state;
    logic         m_tc;

    down_timer #(.W(4)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .en         (en),
        .auto_reload(auto_reload),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .tc         (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the oldest expectation just after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            vec_cnt++;
            if ({count, busy, done, tc} !== e) begin
                err_cnt++;
                $display("FAIL scoreboard t=%0t: got count=%0d busy=%b done=%b tc=%b, want count=%0d busy=%b done=%b tc=%b",
                         $time, count, busy, done, tc, e.count, e.busy, e.done, e.tc);
            end
        end
    end

    task automatic model_reset();
        m_count  = 4'd0;
        m_reload = 4'd0;
        m_state  = IDLE;
        m_tc     = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic [3:0] lv, input logic s,
                              input logic e, input logic ar);
        m_tc = 1'b0;
        if (l) begin
            m_count  = lv;
            m_reload = lv;
            m_state  = IDLE;
        end else if (m_state != RUN) begin
            if (s && m_reload != 4'd0) begin
                m_count = m_reload;
                m_state = RUN;
            end
        end else if (e) begin
            if (m_count == 4'd1) begin
                m_tc = 1'b1;
                if (ar) m_count = m_reload;
                else begin
                    m_count = 4'd0;
                    m_state = DONE;
                end
            end else begin
                m_count = m_count - 4'd1;
            end
        end
    endtask

    // Apply one cycle of stimulus, queue the expected result, return just after the monitor.
    task automatic drive(input logic l, input logic [3:0] lv, input logic s,
                         input logic e, input logic ar);
        exp_t x;
        @(negedge clk);
        load = l; load_val = lv; start = s; en = e; auto_reload = ar;
        model_step(l, lv, s, e, ar);
        x.count = m_count;
        x.busy  = (m_state == RUN);
        x.done  = (m_state == DONE);
        x.tc    = m_tc;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        load = 1'b0; load_val = 4'd0; start = 1'b0; en = 1'b0; auto_reload = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        vec_cnt++;
        if ({count, busy, done, tc} !== 7'd0) begin
            err_cnt++;
            $display("FAIL reset: got count=%0d busy=%b done=%b tc=%b, want all 0", count, busy, done, tc);
        end
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic test_load();
        drive(1, 4'd5, 0, 0, 0);
        vec_cnt++;
        if (count !== 4'd5 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL load5: got count=%0d busy=%b, want 5/0", count, busy);
        end
        drive(1, 4'd0, 0, 0, 0);
        drive(0, 4'd0, 1, 1, 0);
        vec_cnt++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_zero: got count=%0d busy=%b done=%b, want 0/0/0", count, busy, done);
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] want;
        drive(1, 4'd3, 0, 0, 0);
        drive(0, 4'd0, 1, 1, 0);
        vec_cnt++;
        if (count !== 4'd3 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL oneshot_start: got count=%0d busy=%b, want 3/1", count, busy);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'd0, 0, 1, 0);
            want = 4'(2 - i);
            vec_cnt++;
            if (count !== want || tc !== (i == 2)) begin
                err_cnt++;
                $display("FAIL oneshot_seq%0d: got count=%0d tc=%b, want %0d/%b", i, count, tc, want, (i == 2));
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 4'd0, 0, 1, 0);
            vec_cnt++;
            if (count !== 4'd0 || done !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
                err_cnt++;
                $display("FAIL oneshot_done%0d: got count=%0d done=%b busy=%b tc=%b, want 0/1/0/0",
                         i, count, done, busy, tc);
            end
        end
        drive(0, 4'd0, 1, 0, 0);
        vec_cnt++;
        if (count !== 4'd3 || busy !== 1'b1 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL oneshot_restart: got count=%0d busy=%b done=%b, want 3/1/0", count, busy, done);
        end
    endtask

    task automatic test_auto_reload();
        int pulses = 0;
        int last   = -1;
        int gap_ok = 1;
        int done_seen = 0;
        drive(1, 4'd4, 0, 0, 1);
        drive(0, 4'd0, 1, 1, 1);
        for (int i = 1; i <= 12; i++) begin
            drive(0, 4'd0, 0, 1, 1);
            if (done) done_seen = 1;
            if (tc) begin
                if (last >= 0 && i - last != 4) gap_ok = 0;
                last = i;
                pulses++;
            end
        end
        vec_cnt++;
        if (pulses != 3 || gap_ok != 1 || done_seen != 0 || count !== 4'd4) begin
            err_cnt++;
            $display("FAIL auto_reload: got pulses=%0d gap_ok=%0d done_seen=%0d count=%0d, want 3/1/0/4",
                     pulses, gap_ok, done_seen, count);
        end
    endtask

    task automatic test_pause_priority();
        drive(1, 4'd6, 0, 0, 0);
        drive(0, 4'd0, 1, 1, 0);
        drive(0, 4'd0, 0, 1, 0);
        drive(0, 4'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 4'd0, 1, 0, 0);
            vec_cnt++;
            if (count !== 4'd4 || busy !== 1'b1 || tc !== 1'b0) begin
                err_cnt++;
                $display("FAIL pause%0d: got count=%0d busy=%b tc=%b, want 4/1/0", i, count, busy, tc);
            end
        end
        drive(1, 4'd9, 1, 1, 0);
        vec_cnt++;
        if (count !== 4'd9 || busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_over_start: got count=%0d busy=%b done=%b, want 9/0/0", count, busy, done);
        end
    endtask

    task automatic test_async_reset();
        int tc_seen = 0;
        drive(1, 4'd15, 0, 0, 0);
        drive(0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 8; i++) drive(0, 4'd0, 0, 1, 0);
        vec_cnt++;
        if (count !== 4'd7) begin
            err_cnt++;
            $display("FAIL pre_reset: got count=%0d, want 7", count);
        end
        #1;
        rst_ = 1'b0;
        model_reset();
        #1;
        vec_cnt++;
        if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: got count=%0d busy=%b tc=%b, want 0/0/0", count, busy, tc);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            if (tc) tc_seen = 1;
        end
        @(negedge clk);
        rst_ = 1'b1;
        drive(0, 4'd0, 0, 1, 0);
        if (tc) tc_seen = 1;
        vec_cnt++;
        if (tc_seen != 0 || count !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset_no_tc: got tc_seen=%0d count=%0d, want 0/0", tc_seen, count);
        end
    endtask

    task automatic test_max();
        int tc_at = -1;
        drive(1, 4'd15, 0, 0, 0);
        drive(0, 4'd0, 1, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 4'd0, 0, 1, 0);
            if (tc && tc_at < 0) tc_at = i;
        end
        vec_cnt++;
        if (tc_at != 15 || count !== 4'd0 || done !== 1'b1) begin
            err_cnt++;
            $display("FAIL max_value: got tc_at=%0d count=%0d done=%b, want 15/0/1", tc_at, count, done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_oneshot();
        test_auto_reload();
        test_pause_priority();
        test_async_reset();
        test_max();
        test_random();
        repeat (2) @(posedge clk);
        #3;
        if (sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
